// File: rtl/ds_pkg.sv
// Shared definitions for the 2x2 stride-2 pooling downsampler.
// Build option: DOWNSAMPLER_AVG_EN selects average pooling instead of max pooling.
package ds_pkg;

   localparam int N_DEFAULT = 16;

`ifdef DOWNSAMPLER_AVG_EN
   localparam bit AVG_EN = 1'b1;
`else
   localparam bit AVG_EN = 1'b0;
`endif

   typedef enum logic {
      COMB_MAX,
      COMB_AVG
   } comb_t;

   localparam comb_t COMBINE = AVG_EN ? COMB_AVG : COMB_MAX;

   // What an accepted pixel does, decoded from the parity of its position.
   typedef enum logic [1:0] {
      PH_HOLD,
      PH_STORE,
      PH_EMIT
   } phase_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Averaging keeps the full pair sum, so it needs one extra bit per entry.
   function automatic int entry_width(input int n);
      return AVG_EN ? n + 1 : n;
   endfunction

endpackage

// File: rtl/ds_line_buffer.sv
// Half-row storage of horizontal pair results from the even input row.
// Synchronous write, combinational read, contents deliberately not reset.
module ds_line_buffer
   import ds_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/downsampler.sv
// Streaming 2x2 stride-2 pooling of a raster-order signed image.
// Define DOWNSAMPLER_AVG_EN for floor-average pooling; default is signed max.
module downsampler
   import ds_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] out_data,
   output logic                out_last
);

   localparam int CW = cnt_width(IMG_W);
   localparam int RW = cnt_width(IMG_H);
   localparam int HW = IMG_W / 2;
   localparam int AW = cnt_width(HW);
   localparam int EW = entry_width(N);

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic signed [N-1:0]  hold;
   phase_t               phase;
   logic                 in_fire;
   logic                 out_fire;
   logic                 last_pix;
   logic signed [EW-1:0] h;
   logic signed [EW-1:0] lb_rdata;
   logic [AW-1:0]        lb_addr;
   logic                 lb_we;
   logic signed [N-1:0]  result;

   // Input is only refused while a finished output is waiting for the consumer.
   assign in_ready = !(out_valid && !out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      phase = PH_HOLD;
      if (col[0])
         phase = row[0] ? PH_EMIT : PH_STORE;
   end

   assign lb_addr  = AW'(col >> 1);
   assign lb_we    = in_fire && (phase == PH_STORE);
   assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

   generate
      if (COMBINE == COMB_AVG) begin : g_avg
         logic signed [N+1:0] sum4;
         always_comb begin
            h      = {hold[N-1], hold} + {in_data[N-1], in_data};
            sum4   = {h[EW-1], h} + {lb_rdata[EW-1], lb_rdata};
            result = N'(sum4 >>> 2);
         end
      end else begin : g_max
         always_comb begin
            h      = (in_data > hold) ? in_data : hold;
            result = (lb_rdata > h) ? lb_rdata : h;
         end
      end
   endgenerate

   ds_line_buffer #(
      .DEPTH (HW),
      .W     (EW),
      .AW    (AW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (h),
      .raddr (lb_addr),
      .rdata (lb_rdata)
   );

   // Raster position of the next input pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (in_fire) begin
         if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold <= '0;
      else if (in_fire && (phase == PH_HOLD))
         hold <= in_data;
   end

   // A new result may replace one leaving on the same edge, so there is no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (in_fire && (phase == PH_EMIT)) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= last_pix;
         end
      end
   end

endmodule
